// File: rtl/proc_pkg.sv
// Shared processor definitions: opcode values, instruction field positions,
// sequencer state encoding and small decode helpers.
package proc_pkg;

  localparam int INSTR_W     = 32;
  localparam int DELAY_CNT_W = 4;

  // Instruction field bit positions
  localparam int OPER_MSB     = 31;
  localparam int OPER_LSB     = 27;
  localparam int RDST_MSB     = 26;
  localparam int RDST_LSB     = 22;
  localparam int RSRC1_MSB    = 21;
  localparam int RSRC1_LSB    = 17;
  localparam int IMM_MODE_BIT = 16;
  localparam int RSRC2_MSB    = 15;
  localparam int RSRC2_LSB    = 11;
  localparam int ISRC_MSB     = 15;
  localparam int ISRC_LSB     = 0;

  // Opcodes: 0..11 go to the datapath, 19..30 are treated as NOP
  localparam logic [4:0] OP_LAST_DATAPATH = 5'd11;
  localparam logic [4:0] OP_JMP           = 5'd12;
  localparam logic [4:0] OP_JZ            = 5'd13;
  localparam logic [4:0] OP_JNZ           = 5'd14;
  localparam logic [4:0] OP_JC            = 5'd15;
  localparam logic [4:0] OP_JNC           = 5'd16;
  localparam logic [4:0] OP_JS            = 5'd17;
  localparam logic [4:0] OP_JOV           = 5'd18;
  localparam logic [4:0] OP_HALT          = 5'd31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_DELAY,
    ST_NEXT,
    ST_HALT
  } seq_state_e;

  function automatic logic [4:0] get_oper(input logic [INSTR_W-1:0] instr);
    return instr[OPER_MSB:OPER_LSB];
  endfunction

  function automatic logic [15:0] get_isrc(input logic [INSTR_W-1:0] instr);
    return instr[ISRC_MSB:ISRC_LSB];
  endfunction

  function automatic logic is_datapath_op(input logic [4:0] op);
    return (op <= OP_LAST_DATAPATH);
  endfunction

  // Branch decision; anything that is not a jump (including NOPs) is not taken
  function automatic logic jump_taken(input logic [4:0] op, input logic z,
                                      input logic s, input logic c, input logic o);
    logic taken;
    case (op)
      OP_JMP:  taken = 1'b1;
      OP_JZ:   taken = z;
      OP_JNZ:  taken = ~z;
      OP_JC:   taken = c;
      OP_JNC:  taken = ~c;
      OP_JS:   taken = s;
      OP_JOV:  taken = o;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/seq_delay_counter.sv
// Down-counter timing the post-execute wait. done is high on the last
// wait cycle (count of 1), and also at 0 so a stray entry can never lock up.
module seq_delay_counter
  import proc_pkg::*;
(
  input  logic                   clock,
  input  logic                   system_reset,
  input  logic                   load,
  input  logic [DELAY_CNT_W-1:0] load_value,
  input  logic                   decrement,
  output logic                   done
);

  logic [DELAY_CNT_W-1:0] count_q;
  logic [DELAY_CNT_W-1:0] count_d;

  // Next count: load wins over decrement, saturate at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (decrement && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clock) begin
    if (system_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q <= DELAY_CNT_W'(1));

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches 32-bit words, holds them in ir for the
// datapath, strobes exec_en for datapath ops, resolves jumps from flags and
// advances pc. All outputs come straight from flops.
module instr_sequencer
  import proc_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int EXEC_DELAY = 2
) (
  input  logic              clock,
  input  logic              system_reset,
  input  logic              start,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              flag_zero,
  input  logic              flag_sign,
  input  logic              flag_carry,
  input  logic              flag_overflow,
  output logic [31:0]       ir,
  output logic              exec_en,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  localparam logic [DELAY_CNT_W-1:0] DELAY_LOAD = DELAY_CNT_W'(EXEC_DELAY);
  localparam bit                     HAS_DELAY  = (EXEC_DELAY > 0);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic              taken_q, taken_d;
  logic              exec_en_q, exec_en_d;
  logic              imem_en_q, imem_en_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;

  logic              dly_load;
  logic              dly_dec;
  logic              dly_done;
  logic [4:0]        ir_op;
  logic [ADDR_W-1:0] jump_target;

  assign ir_op       = get_oper(ir_q);
  // isrc is 16 bits; the cast truncates or zero-extends to the pc width
  assign jump_target = ADDR_W'(get_isrc(ir_q));

  seq_delay_counter u_delay (
    .clock        (clock),
    .system_reset (system_reset),
    .load         (dly_load),
    .load_value   (DELAY_LOAD),
    .decrement    (dly_dec),
    .done         (dly_done)
  );

  // Next-state, pc/ir update and output decode; outputs are decoded from the
  // next state so that they are registered and line up with the state
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    taken_d  = taken_q;
    dly_load = 1'b0;
    dly_dec  = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
          taken_d = 1'b0;
        end
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        ir_d    = imem_rdata;
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        taken_d = 1'b0;
        if (is_datapath_op(ir_op)) begin
          if (HAS_DELAY) begin
            dly_load = 1'b1;
            state_d  = ST_DELAY;
          end else begin
            state_d  = ST_NEXT;
          end
        end else if (ir_op == OP_HALT) begin
          state_d = ST_HALT;
        end else begin
          // Jumps and NOPs; NOP opcodes are never taken
          taken_d = jump_taken(ir_op, flag_zero, flag_sign, flag_carry, flag_overflow);
          state_d = ST_NEXT;
        end
      end
      ST_DELAY: begin
        dly_dec = 1'b1;
        if (dly_done) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        pc_d    = taken_q ? jump_target : pc_q + ADDR_W'(1);
        state_d = ST_FETCH;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    imem_en_d   = (state_d == ST_FETCH);
    imem_addr_d = pc_d;
    exec_en_d   = (state_d == ST_EXECUTE) && is_datapath_op(get_oper(ir_d));
    busy_d      = (state_d != ST_IDLE) && (state_d != ST_HALT);
    halted_d    = (state_d == ST_HALT);
  end

  // FSM state and registered outputs; reset overrides everything
  always_ff @(posedge clock) begin
    if (system_reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      taken_q     <= 1'b0;
      exec_en_q   <= 1'b0;
      imem_en_q   <= 1'b0;
      imem_addr_q <= '0;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      taken_q     <= taken_d;
      exec_en_q   <= exec_en_d;
      imem_en_q   <= imem_en_d;
      imem_addr_q <= imem_addr_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
    end
  end

  assign imem_en   = imem_en_q;
  assign imem_addr = imem_addr_q;
  assign ir        = ir_q;
  assign exec_en   = exec_en_q;
  assign pc        = pc_q;
  assign busy      = busy_q;
  assign halted    = halted_q;

endmodule
